self_link_width_serializer: RTL and testbench
=============================================

Name: self_link_width_serializer

Overview:
- Width-down converter between two SELF valid/stop links: accepts one wide word (Ratio × DataWidth bits) on the upstream link and transmits it as Ratio narrow beats on the downstream link, least-significant slice first.
- Sits at the transmit side of narrow SELF channels, e.g. between wide kernel datapaths and narrow stream interfaces. It is the counterpart of a width-up deserializer and chains directly with SELF elastic buffers.

Parameters:
- DataWidth, 16, width of each output beat in bits.
- Ratio, 4, number of output beats per input word; legal range 2..16.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- srst  input  1  synchronous reset, active high.
- dataIn  input  DataWidth*Ratio  upstream wide word.
- dataInValid  input  1  upstream word valid.
- dataInStop  output  1  upstream backpressure; a transfer occurs when dataInValid=1 and dataInStop=0.
- dataOut  output  DataWidth  downstream beat.
- dataOutValid  output  1  downstream beat valid.
- dataOutLast  output  1  high with the final beat (index Ratio-1) of each word.
- dataOutStop  input  1  downstream backpressure; a transfer occurs when dataOutValid=1 and dataOutStop=0.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (srst).
- State: shift/hold register (DataWidth*Ratio bits), beat index (ceil(log2 Ratio) bits), and holdValid flag.
- Reset, applied at the clock edge with srst=1:
  - holdValid=0 and beat index=0, so dataOutValid=0 and dataOutLast=0.
  - dataOut contents are don't-care; the bench compares them only when valid.
- While srst=1, dataInStop is forced to 1 combinationally. After reset releases: dataInStop=0.
- Reset mid-word discards the remaining beats. No partial beats are emitted after reset.
- Outputs:
  - dataOut = hold slice [index*DataWidth +: DataWidth].
  - dataOutValid = holdValid.
  - dataOutLast = holdValid and (index == Ratio-1).
- Downstream beat transfer (holdValid=1 and dataOutStop=0):
  - If index < Ratio-1: index increments.
  - If index == Ratio-1: index returns to 0 and holdValid clears, unless a new word is loaded in the same cycle.
- dataInStop = srst OR (holdValid AND NOT (dataOutLast AND NOT dataOutStop)). This is the only combinational path from dataOutStop to dataInStop.
- Upstream accept (dataInValid=1, dataInStop=0): dataIn loads into the hold register, index=0, holdValid=1.
- Load on final beat: when the final beat transfers and a new word is accepted in the same cycle, the load wins. There is no bubble, so sustained throughput is 1 beat/cycle.
- Latency: word accepted at edge N; beat 0 is valid in the cycle after edge N (registered, 1-cycle latency). Beat k transfers no earlier than the cycle after edge N+k.
- Stability: while dataOutValid=1 and dataOutStop=1, dataOut, dataOutValid and dataOutLast hold unchanged.
- dataOutValid never deasserts without a transfer, except on reset.
- dataInValid=1 while dataInStop=1: the word is not captured; upstream must hold it.
- dataOutStop may be asserted while dataOutValid=0; this has no effect.
- dataInValid=0 at the final-beat transfer: holdValid clears, and the next cycle shows dataOutValid=0 and dataInStop=0.

Test Plan:
1. Basic word: DataWidth=16, Ratio=4, dataOutStop=0; send 0x4444_3333_2222_1111 → beats 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles starting 1 cycle after accept; dataOutLast high only with 0x4444; dataInStop=1 during the first 3 beats and 0 on the 4th.
2. Back-to-back: 3 words continuously valid, no stop → 12 consecutive valid beats with no gap; each word is accepted on its predecessor's final-beat cycle.
3. Backpressure: dataOutStop=1 for 5 cycles starting with beat 1 → beat 1 (0x2222) held stable for those 5 cycles; the beat order is unchanged; no beat is duplicated or lost.
4. Stop on last beat: dataOutStop=1 while beat 0x4444 is presented and next word valid → dataInStop=1 and the next word is not taken; it is taken in the cycle dataOutStop drops.
5. Reset mid-word: srst=1 for 1 cycle after beat 0x2222 transfers → dataOutValid=0 next cycle; 0x3333 and 0x4444 are never emitted; dataInStop=1 during srst; the next word serializes normally from 0x1111-slot.
6. Random: random dataInValid/dataOutStop (50%), 1000 words → the output beat stream equals the scoreboard LSB-first expansion, and dataOutLast marks every 4th beat.

Source files
------------

// File: rtl/self_link_width_serializer_if.sv
// SELF valid/stop link pair for the width-down serializer: wide upstream word in, narrow beats out.
// master is the environment side, slave is the serializer side.
interface self_link_width_serializer_if #(
    parameter int DataWidth = 16,
    parameter int Ratio     = 4
);
    logic [DataWidth*Ratio-1:0] dataIn;
    logic                       dataInValid;
    logic                       dataInStop;
    logic [DataWidth-1:0]       dataOut;
    logic                       dataOutValid;
    logic                       dataOutLast;
    logic                       dataOutStop;

    modport master (
        output dataIn, dataInValid, dataOutStop,
        input  dataInStop, dataOut, dataOutValid, dataOutLast
    );

    modport slave (
        input  dataIn, dataInValid, dataOutStop,
        output dataInStop, dataOut, dataOutValid, dataOutLast
    );
endinterface

// File: rtl/self_link_width_serializer.sv
// Width-down converter: one wide SELF word becomes Ratio narrow beats, least-significant slice first.
// A new word may load on the final-beat transfer, so sustained throughput is one beat per cycle.
module self_link_width_serializer #(
    parameter int DataWidth = 16,
    parameter int Ratio     = 4
) (
    input logic clk,
    input logic srst,
    self_link_width_serializer_if.slave link
);
    localparam int IdxW = $clog2(Ratio);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

    logic [Ratio-1:0][DataWidth-1:0] hold;
    logic [IdxW-1:0]                 beatIdx;
    logic                            holdValid;
    logic                            lastBeat;
    logic                            accept;
    logic                            beatXfer;

    assign lastBeat = holdValid && (beatIdx == LastIdx);
    assign beatXfer = holdValid && !link.dataOutStop;

    // Upstream may only load when the hold register is empty or is emptying this cycle.
    assign link.dataInStop = srst || (holdValid && !(lastBeat && !link.dataOutStop));
    assign accept          = link.dataInValid && !link.dataInStop;

    assign link.dataOut      = hold[beatIdx];
    assign link.dataOutValid = holdValid;
    assign link.dataOutLast  = lastBeat;

    always_ff @(posedge clk) begin
        if (srst) begin
            holdValid <= 1'b0;
            beatIdx   <= '0;
        end else if (accept) begin
            holdValid <= 1'b1;
            beatIdx   <= '0;
        end else if (beatXfer) begin
            if (lastBeat) begin
                holdValid <= 1'b0;
                beatIdx   <= '0;
            end else begin
                beatIdx <= beatIdx + 1'b1;
            end
        end
    end

    // Data path carries no reset; contents only matter while holdValid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= link.dataIn;
        end
    end
endmodule

// File: tb/tb_self_link_width_serializer.sv
// Bench for self_link_width_serializer: directed scenarios plus random traffic against a beat-queue model.
// The model holds the beats still owed downstream; every output and dataInStop is derived from it.
module tb_self_link_width_serializer;
    localparam int DW = 16;
    localparam int R  = 4;
    localparam int WW = DW * R;

    logic clk = 1'b0;
    logic srst;

    self_link_width_serializer_if #(.DataWidth(DW), .Ratio(R)) link ();

    self_link_width_serializer #(.DataWidth(DW), .Ratio(R)) dut (
        .clk  (clk),
        .srst (srst),
        .link (link)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    logic [WW-1:0] srcQ[$];
    logic [DW-1:0] beatQ[$];

    task automatic checkVal(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic step(input bit rst, input bit want, input bit stop);
        bit            expValid, expLast, expStop, inXfer, outXfer;
        logic [WW-1:0] w;
        @(negedge clk);
        srst             = rst;
        link.dataOutStop = stop;
        link.dataInValid = want && (srcQ.size() > 0);
        link.dataIn      = (srcQ.size() > 0) ? srcQ[0] : '0;
        #1;
        expValid = beatQ.size() > 0;
        expLast  = beatQ.size() == 1;
        expStop  = rst || (beatQ.size() > 1) || (beatQ.size() == 1 && stop);
        checkVal("dataOutValid", WW'(link.dataOutValid), WW'(expValid));
        checkVal("dataOutLast", WW'(link.dataOutLast), WW'(expLast));
        checkVal("dataInStop", WW'(link.dataInStop), WW'(expStop));
        if (expValid) checkVal("dataOut", WW'(link.dataOut), WW'(beatQ[0]));
        inXfer  = link.dataInValid && !expStop;
        outXfer = expValid && !stop;
        w       = link.dataIn;
        @(posedge clk);
        if (rst) begin
            beatQ.delete();
        end else begin
            if (outXfer) void'(beatQ.pop_front());
            if (inXfer) begin
                for (int k = 0; k < R; k++) beatQ.push_back(w[k*DW +: DW]);
            end
        end
        if (inXfer) void'(srcQ.pop_front());
    endtask

    initial begin
        int cyc;
        srst             = 1'b1;
        link.dataIn      = '0;
        link.dataInValid = 1'b0;
        link.dataOutStop = 1'b0;
        repeat (2) @(posedge clk);
        step(1, 0, 0);
        step(0, 0, 0);

        // Basic word.
        srcQ.push_back(64'h4444_3333_2222_1111);
        repeat (6) step(0, 1, 0);

        // Back-to-back words.
        srcQ.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        srcQ.push_back(64'h0123_4567_89AB_CDEF);
        srcQ.push_back(64'hFEDC_BA98_7654_3210);
        repeat (15) step(0, 1, 0);

        // Backpressure from beat 1 for 5 cycles.
        srcQ.push_back(64'h4444_3333_2222_1111);
        step(0, 1, 0);
        step(0, 0, 0);
        repeat (5) step(0, 0, 1);
        repeat (5) step(0, 0, 0);

        // Stop on the last beat with the next word waiting.
        srcQ.push_back(64'h4444_3333_2222_1111);
        srcQ.push_back(64'h8888_7777_6666_5555);
        step(0, 1, 0);
        repeat (3) step(0, 1, 0);
        repeat (3) step(0, 1, 1);
        repeat (6) step(0, 1, 0);

        // Reset mid-word after beat 1 transfers; next word serializes from slot 0.
        srcQ.push_back(64'h4444_3333_2222_1111);
        srcQ.push_back(64'hDDDD_CCCC_BBBB_AAAA);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 1);
        repeat (7) step(0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 1000; i++) srcQ.push_back({$urandom, $urandom});
        cyc = 0;
        while ((srcQ.size() > 0 || beatQ.size() > 0) && cyc < 40000) begin
            step(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            cyc++;
        end
        checkVal("randomDrained", WW'(srcQ.size() + beatQ.size()), '0);
        step(0, 0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
